// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants, types and helpers for the parametrised synchronous FIFO.
//
// Contents:
//   DEF_DATA_WIDTH / DEF_DEPTH : default geometry (8-bit words, 16 entries)
//   ptr_width()                : pointer/count width for a given depth,
//                                $clog2(depth)+1 (address bits plus wrap bit)
//   DEF_PTR_W                  : ptr_width() at the default depth
//   fifo_ptr_t                 : pointer layout {wrap, addr} at default depth
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    // One extra bit above the address distinguishes "same slot, same lap"
    // (empty) from "same slot, one lap ahead" (full).
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_PTR_W = ptr_width(DEF_DEPTH);

    // Pointer layout. The top level declares the same {wrap, addr} shape
    // resized to its DEPTH parameter.
    typedef struct packed {
        logic                   wrap;
        logic [DEF_PTR_W-2:0]   addr;
    } fifo_ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// DEPTH x DATA_WIDTH storage for fifo_sync_param. One synchronous write
// port and one asynchronous (combinational) read port. Contents are never
// reset; the owning FIFO guarantees stale words are never presented.
//
// Ports:
//   clk_i    : clock, write on rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_ram

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and sticky overflow / underflow
// error flags.
//
// Build option:
//   FIFO_FWFT_EN : when defined, first-word-fall-through read mode -- the
//                  head entry is shown on data_out whenever the FIFO is not
//                  empty and rd_en pops it. When undefined, data_out is a
//                  register loaded by each accepted read (latency 1) and
//                  holds until the next accepted read.
//
// Parameters:
//   DATA_WIDTH : word width in bits (>= 1)
//   DEPTH      : number of entries, power of two, >= 4
//   AF_THRESH  : almost_full when count >= AF_THRESH
//   AE_THRESH  : almost_empty when count <= AE_THRESH
//
// Ports:
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   wr_en        : write request, accepted when not full
//   data_in      : write data, sampled with wr_en
//   rd_en        : read request, accepted when not empty
//   data_out     : read data
//   full         : count == DEPTH            (registered)
//   empty        : count == 0                (registered)
//   almost_full  : count >= AF_THRESH        (registered)
//   almost_empty : count <= AE_THRESH        (registered)
//   count        : occupancy 0..DEPTH        (registered)
//   overflow     : sticky, set by a write request while full
//   underflow    : sticky, set by a read request while empty
//   clr_err      : synchronous clear of overflow / underflow
// ---------------------------------------------------------------------------
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [ptr_width(DEPTH)-1:0]  count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = ptr_width(DEPTH);

    typedef struct packed {
        logic          wrap;
        logic [AW-1:0] addr;
    } ptr_t;

    // The whole {wrap, addr} word counts modulo 2*DEPTH, so the address
    // field wraps at DEPTH and the wrap bit toggles once per lap.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return ptr_t'(p + ptr_t'(1));
    endfunction

    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  full_q,   full_d;
    logic                  empty_q,  empty_d;
    logic                  afull_q,  afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q,    ovf_d;
    logic                  udf_q,    udf_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Acceptance looks only at registered flags, so a read while full
    // frees a slot next cycle but does not let a same-cycle write in.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q.addr),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q.addr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flags are decoded from the next count and registered, so they
        // change on the same edge as count and never follow wr_en/rd_en
        // combinationally.
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(AF_THRESH));
        aempty_d = (count_d <= CW'(AE_THRESH));

        // A new error event takes priority over a coincident clear.
        ovf_d = (wr_en & full_q)  | (ovf_q & ~clr_err);
        udf_d = (rd_en & empty_q) | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry shown straight from the RAM read port. Forced to zero
    // while empty so a stale slot is never visible (including after reset).
    assign data_out = empty_q ? '0 : ram_rdata;
`else
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (rd_acc) begin
            dout_d = ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign data_out = dout_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule : fifo_sync_param

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;
    logic       clr_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_sync_param dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    // Stimulus helpers: drive only; every comparison lives in a test task.
    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; data_in = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Returns the word popped by this read in either read mode.
    task automatic pop(output logic [7:0] v);
`ifdef FIFO_FWFT_EN
        v = data_out;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        v = data_out;
`endif
    endtask

    task automatic test_reset();
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (empty !== 1'b1)        begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0)         begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b exp=1", almost_empty); end
        total++; if (almost_full !== 1'b0)  begin bad++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
        total++; if (count !== 5'd0)        begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (data_out !== 8'h00)    begin bad++; $display("FAIL reset_dout got=%h exp=00", data_out); end
        total++; if (overflow !== 1'b0)     begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if (underflow !== 1'b0)    begin bad++; $display("FAIL reset_udf got=%b exp=0", underflow); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
        total++; if (count !== 5'd8)        begin bad++; $display("FAIL basic_count8 got=%0d exp=8", count); end
        total++; if (empty !== 1'b0)        begin bad++; $display("FAIL basic_empty got=%b exp=0", empty); end
        total++; if (almost_empty !== 1'b0) begin bad++; $display("FAIL basic_aempty got=%b exp=0", almost_empty); end
`ifdef FIFO_FWFT_EN
        total++; if (data_out !== 8'hA0)    begin bad++; $display("FAIL basic_fwft_head got=%h exp=a0", data_out); end
`else
        total++; if (data_out !== 8'h00)    begin bad++; $display("FAIL basic_dout_idle got=%h exp=00", data_out); end
`endif
        for (int i = 0; i < 4; i++) begin
            pop(v);
            total++; if (v !== 8'(8'hA0 + i)) begin bad++; $display("FAIL basic_rd%0d got=%h exp=%h", i, v, 8'(8'hA0 + i)); end
        end
        total++; if (count !== 5'd4)        begin bad++; $display("FAIL basic_count4 got=%0d exp=4", count); end
    endtask

    task automatic test_full_drain();
        logic [7:0] v;
        logic [7:0] prev;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h10 + i));
            total++; if (count !== 5'(i + 1))          begin bad++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, count, i + 1); end
            total++; if (almost_full !== (i + 1 >= 14)) begin bad++; $display("FAIL fill_afull%0d got=%b", i, almost_full); end
            total++; if (full !== (i + 1 == 16))        begin bad++; $display("FAIL fill_full%0d got=%b", i, full); end
        end
        push(8'hEE);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        total++; if (count !== 5'd16)   begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
        // Clear coinciding with another write-while-full: set wins.
        clr_err = 1'b1; wr_en = 1'b1; data_in = 8'hEF;
        @(posedge clk); #1;
        clr_err = 1'b0; wr_en = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        for (int i = 0; i < 16; i++) begin
            pop(v);
            total++; if (v !== 8'(8'h10 + i)) begin bad++; $display("FAIL drain_rd%0d got=%h exp=%h", i, v, 8'(8'h10 + i)); end
        end
        total++; if (empty !== 1'b1)  begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
        total++; if (count !== 5'd0)  begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
        total++; if (full !== 1'b0)   begin bad++; $display("FAIL drain_full got=%b exp=0", full); end
        prev = data_out;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_set got=%b exp=1", underflow); end
        total++; if (data_out !== prev)  begin bad++; $display("FAIL udf_dout got=%h exp=%h", data_out, prev); end
        total++; if (count !== 5'd0)     begin bad++; $display("FAIL udf_count got=%0d exp=0", count); end
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL clr_udf got=%b exp=0", underflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 6; i++) push(8'(8'hB0 + i));
            for (int i = 0; i < 6; i++) begin
                pop(v);
                total++; if (v !== 8'(8'hB0 + i)) begin bad++; $display("FAIL wrap_r%0d_rd%0d got=%h exp=%h", r, i, v, 8'(8'hB0 + i)); end
            end
            total++; if (count !== 5'd0) begin bad++; $display("FAIL wrap_r%0d_count got=%0d exp=0", r, count); end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] v;
        logic [7:0] exp_q [$];
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h55;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        total++; if (count !== 5'd5) begin bad++; $display("FAIL both_mid_count got=%0d exp=5", count); end
`ifdef FIFO_FWFT_EN
        total++; if (data_out !== 8'h51) begin bad++; $display("FAIL both_mid_dout got=%h exp=51", data_out); end
`else
        total++; if (data_out !== 8'h50) begin bad++; $display("FAIL both_mid_dout got=%h exp=50", data_out); end
`endif
        for (int i = 0; i < 11; i++) push(8'(8'h60 + i));
        total++; if (full !== 1'b1) begin bad++; $display("FAIL both_prefull got=%b exp=1", full); end
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h99;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        total++; if (count !== 5'd15)   begin bad++; $display("FAIL both_full_count got=%0d exp=15", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL both_full_ovf got=%b exp=1", overflow); end
        total++; if (full !== 1'b0)     begin bad++; $display("FAIL both_full_flag got=%b exp=0", full); end
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL both_clr_ovf got=%b exp=0", overflow); end
        exp_q = {8'h52, 8'h53, 8'h54, 8'h55};
        for (int i = 0; i < 11; i++) exp_q.push_back(8'(8'h60 + i));
        for (int i = 0; i < 15; i++) begin
            pop(v);
            total++; if (v !== exp_q[i]) begin bad++; $display("FAIL both_drain%0d got=%h exp=%h", i, v, exp_q[i]); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL both_preempty got=%b exp=1", empty); end
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        total++; if (count !== 5'd1)     begin bad++; $display("FAIL both_empty_count got=%0d exp=1", count); end
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL both_empty_udf got=%b exp=1", underflow); end
        total++; if (empty !== 1'b0)     begin bad++; $display("FAIL both_empty_flag got=%b exp=0", empty); end
        pop(v);
        total++; if (v !== 8'h77) begin bad++; $display("FAIL both_empty_word got=%h exp=77", v); end
    endtask

    task automatic test_reset_midburst();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 10; i++) push(8'(8'h90 + i));
        pop(v);
        total++; if (v !== 8'h90)    begin bad++; $display("FAIL mid_pre_rd got=%h exp=90", v); end
        total++; if (count !== 5'd9) begin bad++; $display("FAIL mid_pre_count got=%0d exp=9", count); end
        // Burst still in progress when reset drops mid-cycle.
        wr_en = 1'b1; data_in = 8'h9A;
        #3 reset_n = 1'b0;
        #1;
        total++; if (count !== 5'd0)        begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1)        begin bad++; $display("FAIL mid_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0)         begin bad++; $display("FAIL mid_full got=%b exp=0", full); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL mid_aempty got=%b exp=1", almost_empty); end
        total++; if (almost_full !== 1'b0)  begin bad++; $display("FAIL mid_afull got=%b exp=0", almost_full); end
        total++; if (data_out !== 8'h00)    begin bad++; $display("FAIL mid_dout got=%h exp=00", data_out); end
        total++; if (overflow !== 1'b0)     begin bad++; $display("FAIL mid_ovf got=%b exp=0", overflow); end
        total++; if (underflow !== 1'b0)    begin bad++; $display("FAIL mid_udf got=%b exp=0", underflow); end
        wr_en = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL mid_post_empty got=%b exp=1", empty); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_post_dout got=%h exp=00", data_out); end
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
        test_reset();
        test_basic();
        test_full_drain();
        test_wrap();
        test_simultaneous();
        test_reset_midburst();
        test_basic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_sync_param
